regfile_nbyte: RTL

//  Parametrised register file built from the N-bit register. It holds NUM_REGS words of 8*B bits.
//  - One write port with per-byte write enables.
//  - Two combinational read ports with optional write-to-read bypass.
//  - Sticky error flag for illegal addresses and unknown control values.

---
 rtl/regfile_nbyte.sv | 111 +++++++++++
 1 files changed

// File: rtl/regfile_nbyte.sv
// regfile_nbyte: architectural register file, NUM_REGS words of 8*B bits.
//   One write port with per-byte enables. Two combinational read ports with
//   optional same-cycle write-to-read bypass. Sticky error flag for
//   out-of-range addresses and unknown control values.
// Ports:
//   clk        clock, state updates on rising edge
//   rst        asynchronous active-low reset
//   writeEn    write request
//   writeReg   write address
//   writeData  write data
//   byteEn     per-byte write mask, bit i covers writeData[8i+7:8i]
//   read1Reg   read port 1 address
//   read1Data  read port 1 data (combinational)
//   read2Reg   read port 2 address
//   read2Data  read port 2 data (combinational)
//   errClr     clear the sticky error flag
//   err        sticky error flag (registered)
module regfile_nbyte #(
  parameter int B        = 2,
  parameter int N        = 8 * B,
  parameter int NUM_REGS = 8,
  parameter int AW       = $clog2(NUM_REGS),
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_R0  = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          writeEn,
  input  logic [AW-1:0] writeReg,
  input  logic [N-1:0]  writeData,
  input  logic [B-1:0]  byteEn,
  input  logic [AW-1:0] read1Reg,
  output logic [N-1:0]  read1Data,
  input  logic [AW-1:0] read2Reg,
  output logic [N-1:0]  read2Data,
  input  logic          errClr,
  output logic          err
);

  logic [N-1:0] mem_q [NUM_REGS];
  logic [N-1:0] mem_d [NUM_REGS];
  logic         err_q, err_d;

  logic             wr_in_range;
  logic             wr_legal;
  logic [1:0]       rd_in_range;
  logic [1:0][AW-1:0] rd_addr;
  logic [1:0][N-1:0]  rd_data;
  logic             x_err;
  logic             err_set;

  function automatic logic [N-1:0] merge_bytes(input logic [N-1:0] old_w,
                                               input logic [N-1:0] new_w,
                                               input logic [B-1:0] be);
    logic [N-1:0] r;
    r = old_w;
    for (int i = 0; i < B; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  assign rd_addr[0] = read1Reg;
  assign rd_addr[1] = read2Reg;
  assign read1Data  = rd_data[0];
  assign read2Data  = rd_data[1];
  assign err        = err_q;

  // Simulation-only detection of unknown controls; constant 0 in hardware.
  assign x_err = $isunknown({writeEn, byteEn, writeReg, read1Reg, read2Reg});

  always_comb begin
    wr_in_range = (32'(writeReg) < NUM_REGS);
    wr_legal    = writeEn && wr_in_range && !(ZERO_R0 && (writeReg == '0));
    for (int i = 0; i < NUM_REGS; i++) mem_d[i] = mem_q[i];
    if (wr_legal) mem_d[writeReg] = merge_bytes(mem_q[writeReg], writeData, byteEn);
  end

  always_comb begin
    rd_in_range = '0;
    rd_data     = '0;
    for (int p = 0; p < 2; p++) begin
      rd_in_range[p] = (32'(rd_addr[p]) < NUM_REGS);
      if (rd_in_range[p]) begin
        rd_data[p] = mem_q[rd_addr[p]];
        // wr_legal already excludes r0 when ZERO_R0, so bypass never leaks into r0.
        if (BYPASS && wr_legal && (rd_addr[p] == writeReg))
          rd_data[p] = merge_bytes(mem_q[rd_addr[p]], writeData, byteEn);
      end
      if (ZERO_R0 && (rd_addr[p] == '0)) rd_data[p] = '0;
    end
  end

  always_comb begin
    err_set = (writeEn && !wr_in_range) || !rd_in_range[0] || !rd_in_range[1] || x_err;
    err_d   = err_q;
    if (err_set)     err_d = 1'b1;
    else if (errClr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= mem_d[i];
      err_q <= err_d;
    end
  end

endmodule
